// File: rtl/spi_cfg_pkg.sv
// Shared constants, register map and FSM state type for the SPI configuration controller.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_cfg_if.sv
// SPI pins plus the configuration register bank seen by the PWM peripheral.
interface spi_cfg_if;
  import spi_cfg_pkg::*;

  logic              sclk;
  logic              copi;
  logic              ncs;
  logic              cipo;
  logic [DATA_W-1:0] en_reg_out_7_0;
  logic [DATA_W-1:0] en_reg_out_15_8;
  logic [DATA_W-1:0] en_reg_pwm_7_0;
  logic [DATA_W-1:0] en_reg_pwm_15_8;
  logic [DATA_W-1:0] pwm_duty_cycle;
  logic              cfg_wr_pulse;
  logic [ADDR_W-1:0] cfg_wr_addr;

  modport slave (
    input  sclk, copi, ncs,
    output cipo, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle, cfg_wr_pulse, cfg_wr_addr
  );

  modport master (
    output sclk, copi, ncs,
    input  cipo, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle, cfg_wr_pulse, cfg_wr_addr
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with one-cycle rise/fall pulses
// derived from the synchronized level and its previous value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_ff;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= {STAGES{RST_VAL}};
      prev    <= RST_VAL;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], din};
      prev    <= sync_ff[STAGES-1];
    end
  end

  assign level = sync_ff[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// Oversampling SPI slave owning the PWM configuration registers: 16-bit frames,
// writes committed atomically at frame end, reads returned on CIPO.
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_cfg_if.slave    bus
);

  localparam int                IDX_W        = $clog2(NUM_REGS);
  localparam int                CNT_W        = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_ADDR_END = CNT_W'(FRAME_BITS - DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A   = ADDR_W'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  logic ncs_s, ncs_rise_unused, ncs_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(bus.sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(bus.copi),
    .level(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(bus.ncs),
    .level(ncs_s), .rise(ncs_rise_unused), .fall(ncs_fall_unused)
  );

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-2:0] shift;
  logic [DATA_W-1:0]     shadow;
  logic                  read_act;
  logic                  cipo_q;
  logic                  wr_pulse_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     regs [NUM_REGS];

  logic                  shift_en, addr_end, frame_end;
  logic                  rd_req, rd_valid, wr_req, wr_valid;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0]     wr_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A raised ncs always wins over a coincident final edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!ncs_s) state_nxt = SHIFT;
      SHIFT:   if (ncs_s) state_nxt = IDLE;
               else if (frame_end) state_nxt = DONE;
      DONE:    if (ncs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state == SHIFT) && !ncs_s && sclk_rise;
    addr_end  = shift_en && (cnt == CNT_ADDR_END);
    frame_end = shift_en && (cnt == CNT_LAST);
    rd_req    = !shift[ADDR_W-1];
    rd_addr   = {shift[ADDR_W-2:0], copi_s};
    rd_valid  = rd_addr < NUM_REGS_A;
    wr_req    = shift[FRAME_BITS-2];
    wr_addr   = shift[FRAME_BITS-3 -: ADDR_W];
    wr_valid  = wr_addr < NUM_REGS_A;
    wr_data   = {shift[DATA_W-2:0], copi_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shift      <= '0;
      shadow     <= '0;
      read_act   <= 1'b0;
      cipo_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      if (state != SHIFT || ncs_s) begin
        cnt      <= '0;
        read_act <= 1'b0;
        cipo_q   <= 1'b0;
        if (state == IDLE) shift <= '0;
      end else begin
        if (shift_en) begin
          shift <= {shift[FRAME_BITS-3:0], copi_s};
          cnt   <= cnt + 1'b1;
        end
        if (addr_end && rd_req) begin
          shadow   <= rd_valid ? regs[rd_addr[IDX_W-1:0]] : '0;
          read_act <= 1'b1;
        end
        if (frame_end && wr_req && wr_valid) begin
          regs[wr_addr[IDX_W-1:0]] <= wr_data;
          wr_pulse_q               <= 1'b1;
          wr_addr_q                <= wr_addr;
        end
        if (sclk_fall && read_act) begin
          cipo_q <= shadow[DATA_W-1];
          shadow <= {shadow[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.cipo            = cipo_q;
  assign bus.cfg_wr_pulse    = wr_pulse_q;
  assign bus.cfg_wr_addr     = wr_addr_q;
  assign bus.en_reg_out_7_0  = regs[ADDR_EN_OUT_LO[IDX_W-1:0]];
  assign bus.en_reg_out_15_8 = regs[ADDR_EN_OUT_HI[IDX_W-1:0]];
  assign bus.en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO[IDX_W-1:0]];
  assign bus.en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI[IDX_W-1:0]];
  assign bus.pwm_duty_cycle  = regs[ADDR_DUTY[IDX_W-1:0]];

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed frames against a register-array model; register outputs and write strobes checked every cycle.
module tb_spi_cfg_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_cfg_if bus();

  spi_cfg_ctrl #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pulse = 0;
  logic [7:0] model [128];
  logic [6:0] exp_q [$];
  bit         settling;
  bit         prev_pulse;
  logic [7:0] snap_duty;
  logic [7:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register outputs must equal the model outside commit/reset windows.
  always @(negedge clk) begin
    if (!settling && !rst) begin
      chk("en_reg_out_7_0",  bus.en_reg_out_7_0,  model[0]);
      chk("en_reg_out_15_8", bus.en_reg_out_15_8, model[1]);
      chk("en_reg_pwm_7_0",  bus.en_reg_pwm_7_0,  model[2]);
      chk("en_reg_pwm_15_8", bus.en_reg_pwm_15_8, model[3]);
      chk("pwm_duty_cycle",  bus.pwm_duty_cycle,  model[4]);
    end
    if (bus.cfg_wr_pulse === 1'b1) begin
      n_pulse++;
      chk("pulse_width", prev_pulse, 0);
      if (exp_q.size() == 0) chk("spurious_pulse", 1, 0);
      else chk("cfg_wr_addr", bus.cfg_wr_addr, exp_q.pop_front());
    end
    prev_pulse = (bus.cfg_wr_pulse === 1'b1);
  end

  task automatic do_reset();
    settling = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    exp_q.delete();
    tick(1);
    settling = 1'b0;
  endtask

  // SCLK half period is 5 clk cycles; rst_at >= 0 pulses reset before that bit.
  task automatic send(input logic [15:0] w, input int nbits, input int extra, input int rst_at);
    logic [7:0] rd_exp;
    logic [7:0] rd_got;
    bit         is_rd;
    bit         commit;
    is_rd  = !w[15];
    rd_exp = (w[14:8] < 7'd5) ? model[w[14:8]] : 8'h00;
    rd_got = 8'h00;
    commit = w[15] && (w[14:8] < 7'd5) && (nbits == 16) && (rst_at < 0);
    bus.ncs = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) do_reset();
      bus.copi = w[15-i];
      tick(5);
      if (is_rd && i >= 8 && rst_at < 0) begin
        chk("cipo_data", bus.cipo, rd_exp[15-i]);
        rd_got[15-i] = bus.cipo;
      end else begin
        chk("cipo_idle", bus.cipo, 0);
      end
      if (i == 15 && rst_at < 0) begin
        settling = 1'b1;
        if (commit) exp_q.push_back(w[14:8]);
      end
      bus.sclk = 1'b1;
      if (i == 15 && rst_at < 0) begin
        tick(3);
        snap_duty = bus.pwm_duty_cycle;
        tick(2);
        if (commit) model[w[14:8]] = w[7:0];
        settling = 1'b0;
      end else begin
        tick(5);
      end
      bus.sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      bus.copi = 1'($urandom_range(1));
      tick(5);
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
    end
    tick(5);
    bus.ncs = 1'b1;
    tick(6);
    last_rd = rd_got;
  endtask

  initial begin
    rst      = 1'b1;
    settling = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    do_reset();
    chk("rst_out_lo", bus.en_reg_out_7_0, 8'h00);
    chk("rst_out_hi", bus.en_reg_out_15_8, 8'h00);
    chk("rst_pwm_lo", bus.en_reg_pwm_7_0, 8'h00);
    chk("rst_pwm_hi", bus.en_reg_pwm_15_8, 8'h00);
    chk("rst_duty",   bus.pwm_duty_cycle, 8'h00);
    chk("rst_cipo",   bus.cipo, 0);
    chk("rst_pulse",  bus.cfg_wr_pulse, 0);
    chk("rst_waddr",  bus.cfg_wr_addr, 0);

    send(16'h8480, 16, 0, -1);
    chk("duty_3cyc", snap_duty, 8'h80);
    chk("duty_after", bus.pwm_duty_cycle, 8'h80);
    chk("last_waddr", bus.cfg_wr_addr, 7'd4);
    chk("out_lo_untouched", bus.en_reg_out_7_0, 8'h00);

    send(16'h85AA, 16, 0, -1);
    chk("inval_waddr_held", bus.cfg_wr_addr, 7'd4);
    send(16'h80F0, 16, 0, -1);
    chk("out_lo_f0", bus.en_reg_out_7_0, 8'hF0);

    send(16'h8255, 10, 0, -1);
    chk("abort_pwm_lo", bus.en_reg_pwm_7_0, 8'h00);
    send(16'h8255, 16, 0, -1);
    chk("pwm_lo_55", bus.en_reg_pwm_7_0, 8'h55);

    send(16'h833C, 16, 4, -1);
    chk("pwm_hi_3c", bus.en_reg_pwm_15_8, 8'h3C);
    send(16'h0300, 16, 0, -1);
    chk("read_03", last_rd, 8'h3C);
    send(16'h04A5, 16, 0, -1);
    chk("read_04", last_rd, 8'h80);
    send(16'h40FF, 16, 0, -1);
    chk("read_inval", last_rd, 8'h00);
    chk("read_no_side", bus.pwm_duty_cycle, 8'h80);

    send(16'h81FF, 16, 0, 12);
    chk("midrst_out_lo", bus.en_reg_out_7_0, 8'h00);
    chk("midrst_out_hi", bus.en_reg_out_15_8, 8'h00);
    chk("midrst_duty",   bus.pwm_duty_cycle, 8'h00);
    send(16'h81FF, 16, 0, -1);
    chk("out_hi_ff", bus.en_reg_out_15_8, 8'hFF);

    tick(4);
    chk("pending_pulses", exp_q.size(), 0);
    chk("pulse_count", n_pulse, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
